multiplicador_seq: RTL
======================

MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 8 bits and product width at 16 bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port inicio  input  1  start request, sampled on clk rising edge.
REQ-005 SHALL have port a  input  8  multiplicand, unsigned, sampled only on the accepting edge.
REQ-006 SHALL have port b  input  8  multiplier, unsigned, sampled only on the accepting edge.
REQ-007 SHALL have port p  output  16  registered unsigned product a*b.
REQ-008 SHALL have port pronto  output  1  one-cycle pulse: p is valid and updated.
REQ-009 SHALL have port ocupado  output  1  high while an operation is in progress.

Function
REQ-010 SHALL implement the states OCIOSO, SOMA and FIM.
REQ-011 SHALL accept a request only when the state is OCIOSO and inicio=1 at a rising edge (edge E0).
- Action at E0: M<=a, Q<=b, A<=0, C<=0, cnt<=0, state<=SOMA.
REQ-012 SHALL ignore inicio in SOMA and FIM; no queuing; a and b changes have no effect after E0.
REQ-013 SHALL, on each of edges E1..E8 in SOMA, perform one shift-and-add step through the shared 8-bit adder.
- Adder inputs: A and (Q[0] ? M : 0).
- Adder result: 9-bit {c,s}.
- Update: A<={c,s[7:1]}, Q<={s[0],Q[7:1]}, cnt<=cnt+1.
REQ-014 SHALL leave SOMA for FIM on the edge where cnt=7 (E8) and load p<={A_next,Q_next} on that same edge.
REQ-015 SHALL drive pronto=1 only while in FIM, i.e. exactly one cycle between E8 and E9.
REQ-016 SHALL return from FIM to OCIOSO unconditionally at E9.
- Earliest next acceptance is E10.
- With inicio held high, the acceptance period is 10 cycles.
REQ-017 SHALL drive ocupado=1 in SOMA and FIM, and 0 in OCIOSO.
REQ-018 SHALL hold p unchanged from one completion until the next completion edge; a new acceptance SHALL NOT clear p.
REQ-019 SHALL produce the exact 16-bit product for all 65536 operand pairs without overflow.
- Adder carry-out feeds A[7].
- Maximum result is 0xFE01.
REQ-020 SHALL treat zero operands as normal operations with the full 8-iteration latency; no early termination.

Reset
REQ-021 SHALL, on rst=1, asynchronously force state=OCIOSO, p=0, pronto=0, ocupado=0, and A, Q, M, C and cnt to 0.
REQ-022 SHALL abort any in-progress operation on reset with no pronto pulse and p=0.
REQ-023 SHALL accept a request on the first rising edge after rst deasserts if inicio=1.

Structure
REQ-024 SHALL take the state encoding (OCIOSO=2'd0, SOMA=2'd1, FIM=2'd2) and the constants LARGURA=8 and N_ITER=8 from the shared package.
REQ-025 SHALL instantiate exactly one somador_completo (8-bit a, b to 9-bit s) as the datapath adder; no other adder or multiplier operator SHALL be used.
REQ-026 SHALL keep the FSM and the shift registers in this module; the only sub-module is the adder.

Verification
REQ-027 Bench SHALL check: a=3, b=5, inicio pulse at E0 -> ocupado rises after E0; pronto=1 only between E8 and E9; p=0x000F.
REQ-028 Bench SHALL check: a=255, b=255 -> p=0xFE01 at E8, exercising adder carry-out every step.
REQ-029 Bench SHALL check: a=0, b=200 -> p=0x0000, pronto still at E8; previous nonzero p held until E8.
REQ-030 Bench SHALL check: inicio held high, operands 7*9 then 12*12 -> acceptances at E0 and E10; p=0x003F then 0x0090; inicio pulses during ocupado ignored.
REQ-031 Bench SHALL check: rst asserted between E4 and E5 -> p, pronto and ocupado go to 0 immediately and no pronto follows; 10*10 issued after rst release -> p=0x0064.
REQ-032 Bench SHALL check: random a and b over at least 1000 operations -> p equals a*b every time.

Source files
------------

// File: rtl/multiplicador_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add
// multiplier.
package multiplicador_seq_pkg;

    localparam int LARGURA = 8;
    localparam int N_ITER  = 8;
    localparam int CNT_W   = $clog2(N_ITER);

    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        SOMA   = 2'd1,
        FIM    = 2'd2
    } estado_t;

endpackage

// File: rtl/multiplicador_seq_somador.sv
// Ripple-carry adder shared by every iteration of the multiplier;
// the carry-out is returned as the top bit of s.
module somador_completo
    import multiplicador_seq_pkg::*;
(
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA:0]   s
);

    logic vai;

    always_comb begin
        s   = '0;
        vai = 1'b0;
        for (int i = 0; i < LARGURA; i++) begin
            s[i] = a[i] ^ b[i] ^ vai;
            vai  = (a[i] & b[i]) | (vai & (a[i] ^ b[i]));
        end
        s[LARGURA] = vai;
    end

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential 8x8 unsigned multiplier: one add-and-shift per cycle through
// a single adder, result registered on the last iteration.
module multiplicador_seq
    import multiplicador_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic [LARGURA-1:0]     a,
    input  logic [LARGURA-1:0]     b,
    output logic [2*LARGURA-1:0]   p,
    output logic                   pronto,
    output logic                   ocupado
);

    estado_t                estado;
    estado_t                proximo;
    logic [LARGURA-1:0]     reg_a;
    logic [LARGURA-1:0]     reg_q;
    logic [LARGURA-1:0]     reg_m;
    logic [CNT_W-1:0]       cnt;
    logic [2*LARGURA-1:0]   reg_p;

    logic [LARGURA-1:0]     parcela;
    logic [LARGURA:0]       soma;
    logic [LARGURA-1:0]     a_prox;
    logic [LARGURA-1:0]     q_prox;
    logic                   ultimo;
    logic                   aceita;

    assign parcela = reg_q[0] ? reg_m : '0;

    somador_completo u_somador (
        .a (reg_a),
        .b (parcela),
        .s (soma)
    );

    // Carry-out becomes the new MSB of A so the top partial product never overflows
    assign a_prox = soma[LARGURA:1];
    assign q_prox = {soma[0], reg_q[LARGURA-1:1]};
    assign ultimo = (cnt == CNT_ULTIMO);
    assign p      = reg_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        aceita  = 1'b0;
        pronto  = 1'b0;
        ocupado = 1'b1;
        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (inicio) begin
                    aceita  = 1'b1;
                    proximo = SOMA;
                end
            end
            SOMA: begin
                if (ultimo) begin
                    proximo = FIM;
                end
            end
            FIM: begin
                pronto  = 1'b1;
                proximo = OCIOSO;
            end
            default: begin
                ocupado = 1'b0;
                proximo = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a <= '0;
            reg_q <= '0;
            reg_m <= '0;
            cnt   <= '0;
            reg_p <= '0;
        end else if (aceita) begin
            reg_a <= '0;
            reg_q <= b;
            reg_m <= a;
            cnt   <= '0;
        end else if (estado == SOMA) begin
            reg_a <= a_prox;
            reg_q <= q_prox;
            cnt   <= cnt + 1'b1;
            if (ultimo) begin
                reg_p <= {a_prox, q_prox};
            end
        end
    end

endmodule
